// File: rtl/data_mem_pkg.sv
// Shared types and widths for the data memory responder and its word store.
// The state enum is shared so both the top and any debug tooling agree on the encoding.
package data_mem_pkg;

   localparam int WORD_W      = 32;
   localparam int STRB_W      = 4;
   localparam int LAT_CNT_W   = 4;
   localparam int MAX_LATENCY = 15;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

endpackage

// File: rtl/data_mem_responder_word_store.sv
// Word array with asynchronous clear, one combinational read port and one
// byte-enabled synchronous write port.
module word_store
   import data_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_waddr,
   input  logic [WORD_W-1:0] i_wdata,
   input  logic [STRB_W-1:0] i_wstrb,
   input  logic [IDX_W-1:0]  i_raddr,
   output logic [WORD_W-1:0] o_rdata
);

   logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

   // Only bytes whose strobe is set are touched; the rest keep their old value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (i_wstrb[b]) begin
               r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for CPU load/store traffic: one outstanding request,
// fixed access latency, byte-enabled stores and an error flag on the response.
module data_mem_responder
   import data_mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   input  logic [STRB_W-1:0] req_wstrb,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              busy
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   generate
      if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_badLatency
         $error("data_mem_responder: LATENCY must be in 1..15");
      end
   endgenerate

   state_t                r_state;
   state_t                w_stateNext;
   logic [LAT_CNT_W-1:0]  r_cnt;
   logic                  r_write;
   logic [31:0]           r_addr;
   logic [WORD_W-1:0]     r_wdata;
   logic [STRB_W-1:0]     r_wstrb;
   logic [WORD_W-1:0]     r_rdata;
   logic                  r_err;

   logic                  w_accept;
   logic                  w_commit;
   logic                  w_cWrite;
   logic [31:0]           w_cAddr;
   logic [WORD_W-1:0]     w_cWdata;
   logic [STRB_W-1:0]     w_cWstrb;
   logic                  w_err;
   logic                  w_we;
   logic [IDX_W-1:0]      w_idx;
   logic [WORD_W-1:0]     w_rdata;

   assign w_accept = req_valid & (r_state == ST_IDLE);

   // With LATENCY==1 the commit happens on the accept edge itself, so the
   // operands must come straight from the request port rather than the latches.
   assign w_commit = (r_state == ST_IDLE) ? (w_accept & (LATENCY == 1))
                                          : ((r_state == ST_WAIT) & (r_cnt == LAT_CNT_W'(1)));
   assign w_cWrite = (r_state == ST_IDLE) ? req_write : r_write;
   assign w_cAddr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
   assign w_cWdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
   assign w_cWstrb = (r_state == ST_IDLE) ? req_wstrb : r_wstrb;

   assign w_err = (w_cAddr[1:0] != 2'b00) | ({2'b00, w_cAddr[31:2]} >= 32'(DEPTH_WORDS));
   assign w_idx = w_cAddr[IDX_W+1:2];
   assign w_we  = w_commit & w_cWrite & ~w_err;

   word_store #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_store (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_waddr (w_idx),
      .i_wdata (w_cWdata),
      .i_wstrb (w_cWstrb),
      .i_raddr (w_idx),
      .o_rdata (w_rdata)
   );

   always_comb begin
      w_stateNext = r_state;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      busy        = 1'b1;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               w_stateNext = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_cnt == LAT_CNT_W'(1)) begin
               w_stateNext = ST_RESP;
            end
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               w_stateNext = ST_IDLE;
            end
         end
         default: begin
            w_stateNext = ST_IDLE;
         end
      endcase
   end

   // Response registers are loaded only on commit and cleared on handshake,
   // which keeps them stable while the initiator applies backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_write <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
            r_cnt   <= LAT_CNT_W'(LATENCY - 1);
         end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - LAT_CNT_W'(1);
         end
         if (w_commit) begin
            r_rdata <= (w_cWrite | w_err) ? '0 : w_rdata;
            r_err   <= w_err;
         end else if ((r_state == ST_RESP) && resp_ready) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
         end
      end
   end

   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule
